seven_segment_capture: RTL
==========================

Name: seven_segment_capture

Overview:
- Receive side of the team's two-digit multiplexed 7-segment display interface.
- Samples the segment bus and the digit-select pin produced by a display driver (board loopback or an external board) and reconstructs the displayed byte.
- Used for self-test of the display path and for reading values shown by a neighbouring board.
- Performs synchronization, a stability filter, pattern-to-nibble decoding and high/low digit pairing.

Parameters:
- AW, 8, width of the reconstructed value (two hex digits; must be 8).
- DW, 7, segment bus width; pins A..G.
- STABLE_CYCLES, 16, number of consecutive clocks a synchronized sample must be unchanged before it is accepted (range 2..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- seg_in  input  DW  segment levels, bit6=A … bit0=G, 1 = segment lit (common cathode).
- sel_in  input  1  digit select: 1 = left/high digit, 0 = right/low digit.
- data_out  output  AW  last reconstructed byte, {high nibble, low nibble}.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- pattern_err  output  1  qualified by data_valid; 1 if either digit pattern was not a legal hex glyph.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0. Synchronizers, counter, FSM and nibble registers are cleared. Reset mid-frame discards any partial capture.
- Synchronizer: {sel_in, seg_in} passes through 2 flops (s1, s2). A third register, prev, holds s2 from the prior cycle.
- Stability counter cnt (8 bit):
  - If s2 != prev, cnt <= 0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
  - accept is a single-cycle strobe asserted when cnt == STABLE_CYCLES-1 and s2 == prev.
  - Exactly one accept is generated per stable window. Any glitch restarts the count.
- Decode table (7-bit pattern → nibble):
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7
  - 7F→8, 7B→9, 77→A, 1F→b, 4E→C, 3D→d, 4F→E, 47→F
  - Any other pattern, including 00 (blank), decodes to nibble 0 with its illegal flag set.
  - The table must match display_code.list entries 0..15.
- FSM, two states:
  - IDLE:
    - accept with sel=1: store hi nibble and its illegal flag → GOT_HI.
    - accept with sel=0: ignored, stay IDLE.
  - GOT_HI:
    - accept with sel=1: overwrite hi nibble and flag (resync), stay GOT_HI.
    - accept with sel=0: register data_out={hi,lo}, pattern_err = hi_illegal OR lo_illegal, data_valid=1 for one cycle → IDLE.
- Output timing:
  - data_valid/data_out/pattern_err update on the clock edge following the accept cycle.
  - Latency from the low-digit input change to the data_valid pulse is STABLE_CYCLES+3 clocks.
- data_out and pattern_err hold their values between pulses. pattern_err is don't-care when data_valid=0 but is never X.
- A frame needs one high digit followed by one low digit. Consecutive low-digit windows without an intervening high digit produce nothing.
- Arithmetic: only cnt; saturation prevents wrap-around.

Test Plan:
- Reset: hold reset=0 with random inputs → data_out=00, data_valid=0, pattern_err=0. Release with no input activity → no pulse.
- Nominal: alternate sel=1/seg=33 and sel=0/seg=4F, each phase 40 clocks (STABLE_CYCLES=16) → data_valid pulse with data_out=0x4E, pattern_err=0, exactly 19 clocks after the sel=0 phase begins. Repeating frames give one pulse per frame.
- Glitch filter: during the low phase, toggle segment G for 3 clocks at clock 10 → the accept is delayed. The pulse occurs 19 clocks after the glitch ends with the correct value; no extra pulse.
- Illegal/blank: high digit seg=00, low digit seg=30 → data_out=0x01, pattern_err=1.
- Ordering: start the stream in the low phase (sel=0, seg=7E) then high 7F, low 7B → first low phase ignored; single pulse with 0x89. Two high phases 30 then 6D before low 5B → 0x25.
- Reset mid-frame: assert reset during GOT_HI, release, present a low phase only → no pulse. The next full frame 70/77 → 0x7A.

Source files
------------

// File: rtl/seven_segment_capture.sv
// Receive side of the two-digit multiplexed 7-segment link: synchronizes the
// segment/select pins, filters them for stability and rebuilds the shown byte.
module seven_segment_capture #(
    parameter int unsigned AW            = 8,
    parameter int unsigned DW            = 7,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] seg_in,
    input  logic          sel_in,
    output logic [AW-1:0] data_out,
    output logic          data_valid,
    output logic          pattern_err
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] GOT_HI = 1'b1;

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 1);

    // Bit DW carries the digit select, bits DW-1:0 the segment levels.
    logic [DW:0]   s1_q, s1_d;
    logic [DW:0]   s2_q, s2_d;
    logic [DW:0]   prev_q, prev_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [0:0]    state_q, state_d;
    logic [3:0]    hi_q, hi_d;
    logic          hi_ill_q, hi_ill_d;
    logic [AW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    logic          stable;
    logic          accept;
    logic          acc_sel;
    logic [3:0]    dec_nib;
    logic          dec_ill;

    always_comb begin
        s1_d   = {sel_in, seg_in};
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // cnt saturates so a long stable window yields exactly one accept.
    always_comb begin
        stable = (s2_q == prev_q);
        cnt_d  = cnt_q;
        if (!stable) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
        accept  = stable && (cnt_q == CNT_ACC);
        acc_sel = s2_q[DW];
    end

    always_comb begin
        dec_nib = 4'h0;
        dec_ill = 1'b0;
        case (s2_q[DW-1:0])
            7'h7E: dec_nib = 4'h0;
            7'h30: dec_nib = 4'h1;
            7'h6D: dec_nib = 4'h2;
            7'h79: dec_nib = 4'h3;
            7'h33: dec_nib = 4'h4;
            7'h5B: dec_nib = 4'h5;
            7'h5F: dec_nib = 4'h6;
            7'h70: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h7B: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h1F: dec_nib = 4'hB;
            7'h4E: dec_nib = 4'hC;
            7'h3D: dec_nib = 4'hD;
            7'h4F: dec_nib = 4'hE;
            7'h47: dec_nib = 4'hF;
            default: begin
                dec_nib = 4'h0;
                dec_ill = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        hi_ill_d = hi_ill_q;
        data_d   = data_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (acc_sel) begin
                        hi_d     = dec_nib;
                        hi_ill_d = dec_ill;
                        state_d  = GOT_HI;
                    end
                end
                GOT_HI: begin
                    // A repeated high digit overwrites the held one to resync.
                    if (acc_sel) begin
                        hi_d     = dec_nib;
                        hi_ill_d = dec_ill;
                    end else begin
                        data_d  = {hi_q, dec_nib};
                        err_d   = hi_ill_q | dec_ill;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            hi_q     <= '0;
            hi_ill_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            hi_q     <= hi_d;
            hi_ill_q <= hi_ill_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign pattern_err = err_q;

endmodule
